// File: rtl/audio_lock_detect.sv
// LRCK qualifier: measures the word-clock period in clk_in cycles and raises
// audio_locked_out after a run of consistent periods; drops it on deviation or loss.
module audio_lock_detect #(
  parameter int CNT_W       = 10,
  parameter int MIN_PERIOD  = 16,
  parameter int MAX_PERIOD  = 1000,
  parameter int TOL         = 2,
  parameter int LOCK_FRAMES = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             lrck_in,
  output logic             audio_locked_out,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid_out
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  logic             sync1_q, sync2_q, dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [MW-1:0]    match_q, match_d;
  state_t           state_q, state_d;
  logic             locked_q, locked_d;

  logic             edge_pulse;
  logic             in_range;
  logic             is_match;
  logic             timeout;
  logic [CNT_W-1:0] diff;

  assign edge_pulse = sync2_q & ~dly_q;
  assign in_range   = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
  assign diff       = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
  assign is_match   = (diff <= TOL_C);
  assign timeout    = (cnt_q == MAX_C) && !edge_pulse;

  always_comb begin
    cnt_d = cnt_q;
    if (edge_pulse)
      cnt_d = CNT_W'(1);
    else if (cnt_q != MAX_C)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (edge_pulse) state_d = MEASURE;
      end
      MEASURE: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (edge_pulse && in_range) begin
          ref_d   = cnt_q;
          match_d = '0;
          state_d = TRACK;
        end
      end
      TRACK, LOCKED: begin
        if (timeout) begin
          state_d = IDLE;
          match_d = '0;
        end else if (edge_pulse) begin
          if (is_match) begin
            // LOCKED keeps its reference and count; no drift tracking once locked
            if (state_q == TRACK) begin
              match_d = match_q + MW'(1);
              if (match_q + MW'(1) >= LOCK_C) state_d = LOCKED;
            end
          end else if (in_range) begin
            ref_d   = cnt_q;
            match_d = '0;
            state_d = TRACK;
          end else begin
            match_d = '0;
            state_d = MEASURE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      cnt_q    <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      state_q  <= IDLE;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= lrck_in;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      state_q  <= state_d;
      locked_q <= locked_d;
    end
  end

  assign audio_locked_out = locked_q;
  assign period_valid_out = locked_q;
  assign period_out       = ref_q;

endmodule

// File: tb/tb_audio_lock_detect.sv
// Directed bench for audio_lock_detect: lock, jitter, loss, range limits and
// asynchronous reset, with hand-computed expectations.
module tb_audio_lock_detect;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       lrck_in = 1'b0;
  logic       audio_locked_out;
  logic [9:0] period_out;
  logic       period_valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  audio_lock_detect dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .lrck_in          (lrck_in),
    .audio_locked_out (audio_locked_out),
    .period_out       (period_out),
    .period_valid_out (period_valid_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("check %-18s got=%0d exp=%0d ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // One LRCK period of p clocks starting with a rising edge
  task automatic run_periods(input int p, input int n);
    repeat (n) begin
      lrck_in = 1'b1;
      step(p / 2);
      lrck_in = 1'b0;
      step(p - p / 2);
    end
  endtask

  task automatic check_lock(input string tag, input int lk, input int per);
    check({tag, "_locked"}, audio_locked_out, lk);
    check({tag, "_valid"}, period_valid_out, lk);
    check({tag, "_period"}, period_out, per);
  endtask

  int jit_list[8] = '{68, 66, 67, 69, 65, 67, 68, 66};

  initial begin
    // Reset state
    step(3);
    check_lock("reset", 0, 0);
    reset = 1'b0;
    step(2);

    // Clean lock at period 64: 10th rising edge decides lock
    run_periods(64, 9);
    lrck_in = 1'b1;
    step(2);
    check("lock64_early", audio_locked_out, 0);
    step(2);
    check("lock64_at4", audio_locked_out, 1);
    step(32 - 4);
    lrck_in = 1'b0;
    step(32);
    check_lock("lock64", 1, 64);

    // Jitter within tolerance keeps lock and the reference
    for (int i = 0; i < 4; i++) begin
      run_periods(62, 1);
      run_periods(66, 1);
    end
    check_lock("jitter", 1, 64);
    run_periods(67, 1);
    check("pre67_locked", audio_locked_out, 1);
    run_periods(67, 1);
    check_lock("dev67", 0, 67);
    for (int i = 0; i < 7; i++) run_periods(jit_list[i], 1);
    check("relock_7", audio_locked_out, 0);
    run_periods(jit_list[7], 1);
    check_lock("relock_8", 1, 67);

    // Loss of LRCK: timeout 1000 cycles after last edge pulse
    step(930);
    check("loss_before", audio_locked_out, 1);
    step(10);
    check("loss_after", audio_locked_out, 0);
    check("loss_period", period_out, 67);

    // Out of range short period never locks and never updates reference
    run_periods(10, 50);
    check_lock("short10", 0, 67);

    // Boundary periods
    run_periods(16, 12);
    check_lock("min16", 1, 16);
    run_periods(1000, 11);
    check_lock("max1000", 1, 1000);
    run_periods(1001, 6);
    check_lock("over1001", 0, 1000);

    // Asynchronous reset during active lock
    run_periods(16, 12);
    check("pre_rst_locked", audio_locked_out, 1);
    @(posedge clk_in);
    #3;
    reset = 1'b1;
    #1;
    check_lock("async_rst", 0, 0);
    step(2);
    reset = 1'b0;
    run_periods(16, 5);
    check("post_rst_nolock", audio_locked_out, 0);
    check("post_rst_period", period_out, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_lock_detect.md
Name: audio_lock_detect

Overview:
- Qualifies the incoming I2S word clock (LRCK) and produces the audio-locked flag consumed by the amplifier state controller's mute logic.
- Measures the LRCK period in system clocks and declares lock after a run of consistent periods.
- Drops lock on a period deviation or on loss of LRCK.
- Sits between the I2S receiver pins and the amp state control stage.

Parameters:
CNT_W, 10, width of period counter and period_out; must satisfy 2^CNT_W > MAX_PERIOD
MIN_PERIOD, 16, shortest acceptable LRCK period in clk_in cycles
MAX_PERIOD, 1000, longest acceptable period; also the LRCK-loss timeout
TOL, 2, allowed absolute deviation (cycles) between a period and the stored reference
LOCK_FRAMES, 8, consecutive matching periods required to assert lock

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-high reset
lrck_in  input  1  raw LRCK from pin, asynchronous to clk_in
audio_locked_out  output  1  high while LRCK is stable (feeds audio_locked_in of amp state control)
period_out  output  CNT_W  stored reference period in clk_in cycles
period_valid_out  output  1  high when period_out is meaningful; equals audio_locked_out

Behaviour:
- Reset is asynchronous and active-high, with one clock (clk_in).
- Reset state:
  - FSM in IDLE.
  - All outputs 0.
  - Synchronizer flops, counter, reference and match count all 0.
  - Reset asserted mid-operation forces this state immediately, with no clock required.
- Input path:
  - 2-flop synchronizer, then a delay flop.
  - edge = sync & ~delayed, a single-cycle pulse.
  - Latency from an lrck_in rising transition to the edge pulse is 3 clk_in cycles.
- Period counter cnt:
  - Loads 1 in an edge cycle; otherwise increments by 1.
  - Saturates at MAX_PERIOD.
  - Measured period P = cnt value in an edge cycle, i.e. clocks since the previous edge.
- In range: MIN_PERIOD <= P <= MAX_PERIOD.
- Match: |P - ref| <= TOL, computed on unsigned CNT_W values without wrap.
- Timeout: cnt == MAX_PERIOD in a cycle with no edge. If an edge and the max count coincide, the edge wins.
- FSM states and transitions (all evaluated on edge cycles unless stated):
  - IDLE: edge -> MEASURE.
  - MEASURE:
    - P in range -> ref=P, match=0, go to TRACK.
    - P out of range -> stay in MEASURE.
    - Timeout -> IDLE.
  - TRACK:
    - Match -> match+1. When match reaches LOCK_FRAMES -> LOCKED.
    - Mismatch with P in range -> ref=P, match=0, stay in TRACK.
    - Mismatch with P out of range -> MEASURE.
    - Timeout -> IDLE.
  - LOCKED:
    - Match -> stay; ref is not updated (no drift tracking).
    - Mismatch with P in range -> ref=P, match=0, go to TRACK.
    - Mismatch with P out of range -> MEASURE.
    - Timeout -> IDLE.
- Outputs:
  - audio_locked_out is registered, high exactly while the FSM is in LOCKED.
  - It rises and falls on the clock edge that enters or leaves LOCKED, i.e. one cycle after the deciding edge pulse or timeout cycle.
  - period_out holds ref at all times.
  - period_valid_out = audio_locked_out.
- Falling LRCK edges and duty cycle are ignored.
- A glitch shorter than one clk_in may be missed; it is not required to be detected.

Test Plan:
1. Reset: assert reset during an active LRCK -> audio_locked_out, period_valid_out and period_out are all 0 asynchronously; FSM returns to IDLE.
2. Clean lock, LRCK period 64 clk_in:
   - Edge pulses E0, E1, …; E1 stores ref=64.
   - E2..E9 match.
   - audio_locked_out rises 1 cycle after E9, i.e. 4 cycles after the 10th lrck_in rising edge; period_out=64.
3. Jitter, period alternating 62/66 around ref 64 after lock -> remains locked. A single 67-cycle period -> locked drops 1 cycle after that edge, period_out=67. Lock re-asserts after 8 further 67±2 periods.
4. Loss of LRCK: stop toggling while locked -> audio_locked_out falls 1 cycle after cnt reaches 1000, i.e. 1000 cycles after the last edge pulse.
5. Out of range: LRCK period 10 (< MIN_PERIOD) for 50 periods -> never locks; FSM stays in MEASURE.
6. Boundary: period exactly 16 and exactly 1000 -> both lock. Period 1001 -> timeout to IDLE, no lock.
